// File: rtl/hazard_unit.sv
// Hazard control for the 5-stage RV32I pipeline: load-use stall, control flush,
// EX forwarding selects, post-reset pipeline clearing and event counters.
module hazard_fwd (
  input  logic [4:0] rs,
  input  logic [4:0] rdm,
  input  logic [4:0] rdw,
  input  logic       regwritem,
  input  logic       regwritew,
  input  logic       en,
  output logic [1:0] fwd
);
  // M has priority over W; x0 is never forwarded
  always_comb begin
    fwd = 2'b00;
    if (en) begin
      if (regwritem && rdm != 5'd0 && rs == rdm)      fwd = 2'b10;
      else if (regwritew && rdw != 5'd0 && rs == rdw) fwd = 2'b01;
    end
  end
endmodule

module hazard_unit #(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             cnt_clear,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             init_done,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int NUM_OPS = 2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {INIT, RUN} state_t;

  state_t     state;
  logic [3:0] init_cnt;
  logic       run;
  logic       lw_stall;

  // reset forces INIT outputs in the same cycle, not just from the next edge
  assign run       = (state == RUN) && !reset;
  assign init_done = run;
  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));

  always_comb begin
    StallF = 1'b1;
    StallD = 1'b0;
    FlushD = 1'b1;
    FlushE = 1'b1;
    if (run) begin
      if (PCSrcE) begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b1;
      end else begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
      end
    end
  end

  logic [NUM_OPS-1:0][4:0] rs_e;
  logic [NUM_OPS-1:0][1:0] fwd;

  assign rs_e      = {Rs2E, Rs1E};
  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    hazard_fwd u_fwd (
      .rs        (rs_e[i]),
      .rdm       (RdM),
      .rdw       (RdW),
      .regwritem (RegWriteM),
      .regwritew (RegWriteW),
      .en        (run),
      .fwd       (fwd[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      init_cnt    <= 4'(INIT_CYCLES);
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (state == INIT) begin
        init_cnt <= init_cnt - 4'd1;
        if (init_cnt == 4'd1) state <= RUN;
      end
      if (cnt_clear) begin
        stall_count <= '0;
        flush_count <= '0;
      end else if (state == RUN) begin
        if (PCSrcE && flush_count != '1)
          flush_count <= flush_count + CNT_ONE;
        if (!PCSrcE && lw_stall && stall_count != '1)
          stall_count <= stall_count + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table for RUN-state controls and
// forwarding, plus hand-written reset, saturation and mid-run reset sequences.
module tb_hazard_unit;
  localparam int CNT_W = 4;

  logic clk = 0, reset = 1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic RegWriteM, RegWriteW, PCSrcE, cnt_clear;
  logic StallF, StallD, FlushD, FlushE, init_done;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_count, flush_count;

  int total = 0, passed = 0;
  int exp_stall = 0, exp_flush = 0;

  always #5 clk = ~clk;

  hazard_unit #(.INIT_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .cnt_clear(cnt_clear), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .init_done(init_done), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsrc;
    logic       rwm, rww, pcsrc;
    logic       sf, sd, fd, fe;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_ctl(input string name, input logic sf, sd, fd, fe);
    chk({name, ".StallF"}, StallF, sf);
    chk({name, ".StallD"}, StallD, sd);
    chk({name, ".FlushD"}, FlushD, fd);
    chk({name, ".FlushE"}, FlushE, fe);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic zero_in();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; cnt_clear = 0;
  endtask

  task automatic set_lw();
    ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
  endtask

  initial begin
    //          rs1d rs2d rs1e rs2e rde rdm rdw rsrc rwm rww pc  sf sd fd fe fa     fb
    vecs[0]  = '{0,  0,   0,   0,   0,  0,  0,  2'b00, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00};
    vecs[1]  = '{5,  1,   0,   0,   5,  0,  0,  2'b01, 0, 0, 0,  1, 1, 0, 1, 2'b00, 2'b00};
    vecs[2]  = '{0,  1,   0,   0,   0,  0,  0,  2'b01, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00};
    vecs[3]  = '{2,  9,   0,   0,   9,  0,  0,  2'b01, 0, 0, 0,  1, 1, 0, 1, 2'b00, 2'b00};
    vecs[4]  = '{9,  9,   0,   0,   9,  0,  0,  2'b00, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00};
    vecs[5]  = '{5,  0,   0,   0,   5,  0,  0,  2'b01, 0, 0, 1,  0, 0, 1, 1, 2'b00, 2'b00};
    vecs[6]  = '{0,  0,   7,   0,   0,  7,  7,  2'b00, 1, 1, 0,  0, 0, 0, 0, 2'b10, 2'b00};
    vecs[7]  = '{0,  0,   7,   0,   0,  7,  7,  2'b00, 0, 1, 0,  0, 0, 0, 0, 2'b01, 2'b00};
    vecs[8]  = '{0,  0,   3,   0,   0,  0,  3,  2'b00, 1, 1, 0,  0, 0, 0, 0, 2'b01, 2'b00};
    vecs[9]  = '{0,  0,   6,   4,   0,  4,  4,  2'b00, 1, 0, 0,  0, 0, 0, 0, 2'b00, 2'b10};
    vecs[10] = '{0,  0,   0,   0,   0,  0,  0,  2'b00, 1, 1, 1,  0, 0, 1, 1, 2'b00, 2'b00};
    vecs[11] = '{0,  0,   0,   8,   0,  9,  8,  2'b00, 1, 1, 0,  0, 0, 0, 0, 2'b00, 2'b01};

    zero_in();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ctl("rst", 1, 0, 1, 1);
      chk("rst.init_done", init_done, 0);
    end
    chk("rst.stall_count", stall_count, 0);
    chk("rst.flush_count", flush_count, 0);
    // load-use pattern during INIT must neither stall D nor count
    reset = 0;
    set_lw();
    #1 chk_ctl("init1", 1, 0, 1, 1);
    chk("init1.init_done", init_done, 0);
    step();
    chk_ctl("init2", 1, 0, 1, 1);
    chk("init2.init_done", init_done, 0);
    chk("init2.stall_count", stall_count, 0);
    zero_in();
    step();
    chk("run.init_done", init_done, 1);
    chk_ctl("run.idle", 0, 0, 0, 0);
    chk("run.stall_count", stall_count, 0);
    chk("run.flush_count", flush_count, 0);

    for (int i = 0; i < 12; i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw; ResultSrcE = vecs[i].rsrc;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; PCSrcE = vecs[i].pcsrc;
      #2;
      chk_ctl($sformatf("vec%0d", i), vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].fe);
      chk($sformatf("vec%0d.ForwardAE", i), ForwardAE, vecs[i].fa);
      chk($sformatf("vec%0d.ForwardBE", i), ForwardBE, vecs[i].fb);
      if (vecs[i].pcsrc) exp_flush++;
      else if (vecs[i].sd) exp_stall++;
      step();
      chk($sformatf("vec%0d.stall_count", i), stall_count, exp_stall);
      chk($sformatf("vec%0d.flush_count", i), flush_count, exp_flush);
    end

    // saturation of the 4-bit stall counter
    zero_in();
    cnt_clear = 1;
    step();
    chk("clr.stall_count", stall_count, 0);
    chk("clr.flush_count", flush_count, 0);
    cnt_clear = 0;
    set_lw();
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat%0d.stall_count", i), stall_count, (i > 15) ? 15 : i);
    end
    cnt_clear = 1;
    step();
    chk("clr_lw.stall_count", stall_count, 0);
    cnt_clear = 0;
    step();
    chk("post_clr.stall_count", stall_count, 1);

    // reset mid-run while stalling and with forwarding active
    Rs1E = 7; RdM = 7; RegWriteM = 1; Rs2E = 8; RdW = 8; RegWriteW = 1;
    PCSrcE = 1;
    step();
    chk("pre_rst.flush_count", flush_count, 1);
    PCSrcE = 0;
    reset = 1;
    #1;
    chk_ctl("mid_rst", 1, 0, 1, 1);
    chk("mid_rst.ForwardAE", ForwardAE, 0);
    chk("mid_rst.init_done", init_done, 0);
    step();
    reset = 0;
    #1;
    chk_ctl("mid_init", 1, 0, 1, 1);
    chk("mid_init.ForwardAE", ForwardAE, 0);
    chk("mid_init.ForwardBE", ForwardBE, 0);
    chk("mid_init.init_done", init_done, 0);
    chk("mid_init.stall_count", stall_count, 0);
    chk("mid_init.flush_count", flush_count, 0);
    step();
    chk("mid_init2.init_done", init_done, 0);
    step();
    chk("mid_run.init_done", init_done, 1);
    chk("mid_run.ForwardAE", ForwardAE, 2);
    chk("mid_run.ForwardBE", ForwardBE, 1);
    chk_ctl("mid_run", 1, 1, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard control for the 5-stage RV32I pipeline. It is the control-side counterpart of the ID/EX register: it produces FlushE, which that register consumes, and the other stall and flush controls.
- It also generates the EX-stage forwarding selects from the Rs/Rd fields delivered by the pipeline registers.
- It contains a post-reset pipeline-clearing state machine and saturating stall and flush event counters.

Parameters:
- INIT_CYCLES, 2: cycles spent in INIT after reset deasserts, while the pipeline is held flushed. Legal range is 1 to 15.
- CNT_W, 16: width of stall_count and flush_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Rs1D  input  5  decode-stage source register 1.
- Rs2D  input  5  decode-stage source register 2.
- Rs1E  input  5  execute-stage source register 1.
- Rs2E  input  5  execute-stage source register 2.
- RdE  input  5  execute-stage destination register.
- RdM  input  5  memory-stage destination register.
- RdW  input  5  writeback-stage destination register.
- ResultSrcE  input  2  execute-stage result select; 2'b01 means load.
- RegWriteM  input  1  memory-stage register write enable.
- RegWriteW  input  1  writeback-stage register write enable.
- PCSrcE  input  1  branch taken or jump resolved in EX.
- cnt_clear  input  1  synchronous clear of both counters.
- StallF  output  1  hold the PC.
- StallD  output  1  hold the IF/ID register.
- FlushD  output  1  clear the IF/ID register.
- FlushE  output  1  clear the ID/EX register.
- ForwardAE  output  2  ALU operand A select: 00 = RD1E, 01 = writeback result, 10 = ALUResultM.
- ForwardBE  output  2  ALU operand B select, same encoding as ForwardAE.
- init_done  output  1  high in RUN state.
- stall_count  output  CNT_W  number of load-use stall cycles.
- flush_count  output  CNT_W  number of control flushes.

Behaviour:
- States: INIT and RUN. A registered down-counter init_cnt is 4 bits wide.
- reset=1 (any cycle, including mid-operation):
  - Next state is INIT, init_cnt is loaded with INIT_CYCLES, and both counters are set to 0.
  - Outputs while reset is high are the INIT outputs.
- INIT state:
  - Outputs: StallF=1, StallD=0, FlushD=1, FlushE=1, ForwardAE=ForwardBE=00, init_done=0.
  - Each non-reset cycle decrements init_cnt. When init_cnt==1, the next state is RUN.
  - Result: exactly INIT_CYCLES INIT cycles follow the last reset cycle.
  - Counters do not increment in INIT; cnt_clear is still honoured.
- RUN state:
  - init_done=1. RUN is left only by reset.
  - lwStall = (ResultSrcE==2'b01) and (RdE!=0) and ((Rs1D==RdE) or (Rs2D==RdE)).
  - If PCSrcE=1: StallF=0, StallD=0, FlushD=1, FlushE=1. The branch has priority over lwStall.
  - Else if lwStall=1: StallF=1, StallD=1, FlushD=0, FlushE=1.
  - Else all four controls are 0.
- Stall and flush controls are combinational from the current inputs and state (same-cycle).
- Forwarding (combinational, RUN only):
  - ForwardAE=10 if RegWriteM and RdM!=0 and Rs1E==RdM.
  - Else ForwardAE=01 if RegWriteW and RdW!=0 and Rs1E==RdW.
  - Else ForwardAE=00.
  - The M stage has priority over W. ForwardBE is identical using Rs2E.
  - x0 is never forwarded.
- Counters (registered, update at the next edge):
  - In RUN: flush_count increments when PCSrcE=1; stall_count increments when lwStall=1 and PCSrcE=0.
  - Both counters saturate at all-ones and never wrap.
  - cnt_clear=1 forces 0 and wins over a same-cycle increment. reset wins over everything.
- Reset values: state=INIT, init_cnt=INIT_CYCLES, stall_count=0, flush_count=0, init_done=0.

Test Plan:
- Reset high for 3 cycles, then low, with INIT_CYCLES=2 -> FlushD/FlushE/StallF high for the 3 reset cycles plus 2 more; init_done rises on the 3rd cycle after release; counters are 0.
- RUN, ResultSrcE=01, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1, FlushD=0 that cycle; stall_count goes 0->1. With RdE=0 instead -> no stall.
- RUN, PCSrcE=1 and load-use match in the same cycle -> FlushD=FlushE=1, StallF=StallD=0; flush_count +1, stall_count unchanged.
- Rs1E=7, RdM=7, RegWriteM=1, RdW=7, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Rs2E=0 with RdM=0 -> ForwardBE=00.
- CNT_W=4, hold lwStall for 20 cycles -> stall_count saturates at 15. Then cnt_clear together with lwStall -> stall_count=0 next cycle.
- Reset asserted mid-RUN while stalling -> next cycle in INIT, counters 0, forwarding 00, init_done=0.
